// File: rtl/layer_mem_pkg.sv
// layer_mem_pkg: shared state encoding and default geometry for the ping-pong result memory
package layer_mem_pkg;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_ROWS   = 8;
  localparam int DEF_COLS   = 8;
  localparam int DEF_ADDR_W = 16;
  typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/layer_result_bank.sv
// layer_result_bank: one bank, single write port, combinational read, async reset to zero
module layer_result_bank
  import layer_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_ROWS * DEF_COLS,
  parameter int IDX_W  = $clog2(DEF_ROWS * DEF_COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[wr_idx] <= wr_data;
  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/layer_result_pingpong_mem.sv
// layer_result_pingpong_mem: two-bank layer result store with swap, sweep-clear and range checks
module layer_result_pingpong_mem
  import layer_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_row,
  input  logic [ADDR_W-1:0] wr_col,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_row,
  input  logic [ADDR_W-1:0] rd_col,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              swap_req,
  output logic              swap_done,
  input  logic              clear_req,
  output logic              busy,
  output logic              addr_err
);
  localparam int DEPTH = ROWS * COLS;
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
  state_t state, state_nx;
  logic wr_sel, idle, wr_in, rd_in, wr_ok, swap;
  logic [IDX_W-1:0] cnt, wr_idx, rd_idx;
  logic [DATA_W-1:0] bank_data [2];
  assign idle     = state == IDLE;
  assign busy     = state == CLEAR;
  assign wr_ready = idle;
  // full-width compares so high address bits can never alias into range
  assign wr_in  = wr_row < ADDR_W'(ROWS) && wr_col < ADDR_W'(COLS);
  assign rd_in  = rd_row < ADDR_W'(ROWS) && rd_col < ADDR_W'(COLS);
  assign wr_ok  = wr_en && idle && wr_in;
  assign swap   = swap_req && idle;
  assign wr_idx = IDX_W'(32'(wr_row) * COLS + 32'(wr_col));
  assign rd_idx = IDX_W'(32'(rd_row) * COLS + 32'(rd_col));
  always_comb
    state_nx = idle ? (clear_req && !swap_req ? CLEAR : IDLE) : (cnt == LAST ? IDLE : CLEAR);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      wr_sel    <= 1'b0;
      cnt       <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      swap_done <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_sel    <= wr_sel ^ swap;
      cnt       <= busy ? cnt + 1'b1 : '0;
      rd_valid  <= rd_en;
      rd_data   <= rd_en && rd_in ? bank_data[!wr_sel] : '0;
      swap_done <= swap;
      addr_err  <= (rd_en && !rd_in) || (wr_en && idle && !wr_in);
    end
  // the sweep and normal writes share the write bank's single port
  for (genvar g = 0; g < 2; g++) begin : g_bank
    layer_result_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_sel == 1'(g) && (busy || wr_ok)),
      .wr_idx  (busy ? cnt : wr_idx),
      .wr_data (busy ? '0 : wr_data),
      .rd_idx  (rd_idx),
      .rd_data (bank_data[g])
    );
  end
endmodule
